// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline stages, the arbiter and the unified memory.
// The arbiter uses the slave modport; pipeline/memory-side agents use master.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_if;
  logic              stall_dm;
  logic [15:0]       conflict_cnt;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr,
           mem_wdata, stall_if, stall_dm, conflict_cnt
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr,
           mem_wdata, stall_if, stall_dm, conflict_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a single-ported unified memory: data-first priority
// with a fetch starvation bound, fixed-latency access sequencing and stalls.
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t            state, state_nxt;
  logic [3:0]        wcnt;
  logic [3:0]        streak;
  logic [15:0]       conflict_cnt, conflict_nxt;
  logic              grant_if, grant_dm, done, contended;
  logic              mem_en, mem_we, if_ack, dm_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, if_rdata, dm_rdata;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_dm)      state_nxt = BUSY_DM;
        else if (grant_if) state_nxt = BUSY_IF;
      end
      BUSY_IF, BUSY_DM: if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Fetch wins a contended IDLE cycle only once data has won STARVE_MAX in a row.
  always_comb begin
    grant_dm     = 1'b0;
    grant_if     = 1'b0;
    done         = 1'b0;
    contended    = bus.if_req & bus.dm_req;
    conflict_nxt = conflict_cnt;
    if (state == IDLE) begin
      grant_dm = bus.dm_req & ~(bus.if_req & (streak == 4'(STARVE_MAX)));
      grant_if = bus.if_req & ~grant_dm;
      if (contended && conflict_cnt != '1) conflict_nxt = conflict_cnt + 16'd1;
    end else begin
      done = (wcnt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wcnt         <= '0;
      streak       <= '0;
      conflict_cnt <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_ack       <= 1'b0;
      dm_ack       <= 1'b0;
      if_rdata     <= '0;
      dm_rdata     <= '0;
    end else begin
      mem_en       <= grant_if | grant_dm;
      if_ack       <= done & (state == BUSY_IF);
      dm_ack       <= done & (state == BUSY_DM);
      conflict_cnt <= conflict_nxt;
      if (grant_if | grant_dm) begin
        mem_addr  <= grant_dm ? bus.dm_addr : bus.if_addr;
        mem_we    <= grant_dm & bus.dm_we;
        mem_wdata <= grant_dm ? bus.dm_wdata : '0;
        wcnt      <= 4'(MEM_LAT);
        if (grant_dm && bus.if_req) streak <= (streak == 4'hF) ? streak : streak + 4'd1;
        else                        streak <= '0;
      end else if (state != IDLE && wcnt != '0) begin
        wcnt <= wcnt - 4'd1;
      end
      if (done && state == BUSY_IF)            if_rdata <= bus.mem_rdata;
      if (done && state == BUSY_DM && !mem_we) dm_rdata <= bus.mem_rdata;
    end
  end

  assign bus.mem_en       = mem_en;
  assign bus.mem_we       = mem_we;
  assign bus.mem_addr     = mem_addr;
  assign bus.mem_wdata    = mem_wdata;
  assign bus.if_ack       = if_ack;
  assign bus.dm_ack       = dm_ack;
  assign bus.if_rdata     = if_rdata;
  assign bus.dm_rdata     = dm_rdata;
  assign bus.conflict_cnt = conflict_cnt;
  assign bus.stall_if     = bus.if_req & ~if_ack;
  assign bus.stall_dm     = bus.dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model compared every cycle,
// directed scenarios with literal expectations, and latency checks at MEM_LAT 1/15.
module tb_mem_port_arbiter;
  localparam int L  = 2;
  localparam int SM = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b();
  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b1();
  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b15();

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(L), .STARVE_MAX(SM))
    dut (.clk(clk), .reset(rst_n), .bus(b));
  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1), .STARVE_MAX(4))
    dut1 (.clk(clk), .reset(rst_n), .bus(b1));
  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(15), .STARVE_MAX(4))
    dut15 (.clk(clk), .reset(rst_n), .bus(b15));

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Memory environment: fixed-latency read data, junk outside the valid cycle
  logic [63:0] mem [bit [63:0]];
  int          rd_cyc = -1;
  logic [63:0] rd_val = '0;

  function automatic logic [63:0] rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  // Transaction-level model: an access granted in cycle g acks in g+L+2
  bit          m_busy = 0;
  int          g_cyc = 0;
  bit          g_dm = 0, g_we = 0;
  logic [63:0] g_data = '0;
  int          m_streak = 0;
  int          m_conf = 0;
  logic        e_mem_en = 0, e_mem_we = 0, e_if_ack = 0, e_dm_ack = 0;
  logic [63:0] e_mem_addr = '0, e_mem_wdata = '0, e_if_rdata = '0, e_dm_rdata = '0;

  always @(posedge clk) begin
    if (b.mem_en === 1'b1) begin
      if (b.mem_we === 1'b1) mem[b.mem_addr] = b.mem_wdata;
      rd_cyc = cyc + L;
      rd_val = rd(b.mem_addr);
    end
    if (!rst_n) begin
      m_busy = 0; m_streak = 0; m_conf = 0;
      e_mem_en = 0; e_mem_we = 0; e_if_ack = 0; e_dm_ack = 0;
      e_mem_addr = '0; e_mem_wdata = '0; e_if_rdata = '0; e_dm_rdata = '0;
    end else begin
      e_mem_en = 0; e_if_ack = 0; e_dm_ack = 0;
      if (m_busy) begin
        if (cyc == g_cyc + 1 + L) begin
          m_busy = 0;
          if (g_dm) begin
            e_dm_ack = 1;
            if (!g_we) e_dm_rdata = g_data;
          end else begin
            e_if_ack = 1;
            e_if_rdata = g_data;
          end
        end
      end else if (b.if_req || b.dm_req) begin
        if (b.if_req && b.dm_req && m_conf < 65535) m_conf++;
        g_dm = b.dm_req && !(b.if_req && m_streak == SM);
        if (g_dm && b.if_req) m_streak = (m_streak < 15) ? m_streak + 1 : 15;
        else                  m_streak = 0;
        g_cyc       = cyc;
        g_we        = g_dm && b.dm_we;
        e_mem_addr  = g_dm ? b.dm_addr : b.if_addr;
        e_mem_we    = g_we;
        e_mem_wdata = b.dm_wdata;
        e_mem_en    = 1;
        g_data      = rd(e_mem_addr);
        m_busy      = 1;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    b.mem_rdata   = (cyc == rd_cyc) ? rd_val : 64'hBAD0_BAD0_BAD0_BAD0;
    b1.mem_rdata  = 64'hA500_0000 + 64'(cyc);
    b15.mem_rdata = 64'hA500_0000 + 64'(cyc);
  end

  always @(negedge clk) begin
    #1;
    chk("mem_en",   64'(b.mem_en),   64'(e_mem_en));
    chk("mem_we",   64'(b.mem_we),   64'(e_mem_we));
    chk("mem_addr", b.mem_addr,      e_mem_addr);
    if (e_mem_we) chk("mem_wdata", b.mem_wdata, e_mem_wdata);
    chk("if_ack",   64'(b.if_ack),   64'(e_if_ack));
    chk("dm_ack",   64'(b.dm_ack),   64'(e_dm_ack));
    chk("if_rdata", b.if_rdata,      e_if_rdata);
    chk("dm_rdata", b.dm_rdata,      e_dm_rdata);
    chk("stall_if", 64'(b.stall_if), 64'(b.if_req & ~e_if_ack));
    chk("stall_dm", 64'(b.stall_dm), 64'(b.dm_req & ~e_dm_ack));
    chk("conflict_cnt", 64'(b.conflict_cnt), 64'(m_conf));
  end

  // Directed helpers
  int ack_port [16];
  int ack_cyc  [16];
  int n_acks;
  int t_start;

  task automatic run(input bit iq, input bit dq, input int nacc);
    n_acks = 0;
    @(posedge clk); #1;
    b.if_addr = 64'h40; b.dm_addr = 64'h100; b.dm_we = 1'b0;
    b.if_req = iq; b.dm_req = dq;
    t_start = cyc;
    for (int k = 0; k < 100 && n_acks < nacc; k++) begin
      @(negedge clk);
      if (b.dm_ack === 1'b1 || b.if_ack === 1'b1) begin
        ack_port[n_acks] = (b.dm_ack === 1'b1) ? 1 : 0;
        ack_cyc[n_acks]  = cyc;
        n_acks++;
        if (n_acks == nacc) begin b.if_req = 1'b0; b.dm_req = 1'b0; end
      end
    end
    if (n_acks < nacc) begin
      chk("run_timeout", 64'(n_acks), 64'(nacc));
      b.if_req = 1'b0; b.dm_req = 1'b0;
    end
  endtask

  task automatic do_req(input bit dm, input bit we, input logic [63:0] addr,
                        input logic [63:0] wd, output int lat,
                        output logic [63:0] rdata, output bit saw_we);
    int t0;
    bit got;
    got = 0; lat = -1; rdata = '0; saw_we = 0;
    @(posedge clk); #1;
    if (dm) begin b.dm_req = 1'b1; b.dm_we = we; b.dm_addr = addr; b.dm_wdata = wd; end
    else begin b.if_req = 1'b1; b.if_addr = addr; end
    t0 = cyc;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (b.mem_en === 1'b1) saw_we = b.mem_we;
      if ((dm ? b.dm_ack : b.if_ack) === 1'b1) begin
        got = 1;
        lat = cyc - t0;
        rdata = dm ? b.dm_rdata : b.if_rdata;
        if (dm) b.dm_req = 1'b0; else b.if_req = 1'b0;
      end
    end
    if (!got) begin
      chk("req_timeout", 64'(got), 64'(1));
      b.dm_req = 1'b0; b.if_req = 1'b0;
    end
  endtask

  task automatic lat_test(input bit big, input int lat_exp);
    int t0, lat;
    logic [63:0] rdv;
    bit got;
    got = 0; lat = -1; rdv = '0;
    @(posedge clk); #1;
    if (big) b15.if_req = 1'b1; else b1.if_req = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if ((big ? b15.if_ack : b1.if_ack) === 1'b1) begin
        got = 1;
        lat = cyc - t0;
        rdv = big ? b15.if_rdata : b1.if_rdata;
        b1.if_req = 1'b0; b15.if_req = 1'b0;
      end
    end
    chk(big ? "lat15_ack_cycle" : "lat1_ack_cycle", 64'(lat), 64'(lat_exp + 2));
    chk(big ? "lat15_rdata" : "lat1_rdata", rdv, 64'hA500_0000 + 64'(t0 + 1 + lat_exp));
  endtask

  int          lat;
  logic [63:0] rdv;
  bit          swe;
  int          t0;
  int          exp_ord [6] = '{1, 1, 0, 1, 1, 0};

  initial begin
    b.if_req = 0; b.if_addr = '0; b.dm_req = 0; b.dm_we = 0; b.dm_addr = '0; b.dm_wdata = '0;
    b1.if_req = 0; b1.if_addr = 64'h80; b1.dm_req = 0; b1.dm_we = 0; b1.dm_addr = '0; b1.dm_wdata = '0;
    b15.if_req = 0; b15.if_addr = 64'h80; b15.dm_req = 0; b15.dm_we = 0; b15.dm_addr = '0; b15.dm_wdata = '0;
    mem[64'h40] = 64'h0050_0093;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mem_en", 64'(b.mem_en), 64'(0));
    chk("rst_conflict", 64'(b.conflict_cnt), 64'(0));
    chk("rst_if_rdata", b.if_rdata, 64'h0);

    // Single fetch: stall in the request cycle and three BUSY cycles, ack in the fifth
    @(posedge clk); #1;
    b.if_req = 1'b1; b.if_addr = 64'h40;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("fetch_stall_k%0d", k), 64'(b.stall_if), 64'(k < 4));
      chk($sformatf("fetch_mem_en_k%0d", k), 64'(b.mem_en), 64'(k == 1));
      if (k == 1) chk("fetch_mem_addr", b.mem_addr, 64'h40);
      if (k == 4) begin
        chk("fetch_ack", 64'(b.if_ack), 64'(1));
        chk("fetch_rdata", b.if_rdata, 64'h0050_0093);
        b.if_req = 1'b0;
      end
    end

    // Store, load back, second store leaves dm_rdata alone
    do_req(1'b1, 1'b1, 64'h100, 64'hDEAD, lat, rdv, swe);
    chk("store_lat", 64'(lat), 64'(4));
    chk("store_mem_we", 64'(swe), 64'(1));
    chk("store_dm_rdata", rdv, 64'h0);
    do_req(1'b1, 1'b0, 64'h100, 64'h0, lat, rdv, swe);
    chk("load_rdata", rdv, 64'hDEAD);
    chk("load_mem_we", 64'(swe), 64'(0));
    do_req(1'b1, 1'b1, 64'h108, 64'hBEEF, lat, rdv, swe);
    chk("store2_dm_rdata", rdv, 64'hDEAD);

    // Both held: DM DM IF DM DM IF, six contended IDLE cycles
    run(1'b1, 1'b1, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("order_%0d", i), 64'(ack_port[i]), 64'(exp_ord[i]));
    chk("contend_spacing", 64'(ack_cyc[5] - t_start), 64'(24));
    @(negedge clk);
    chk("conflict_after_6", 64'(b.conflict_cnt), 64'(6));

    // Data only: back-to-back every MEM_LAT+2 cycles, no streak growth
    run(1'b0, 1'b1, 4);
    chk("dm_only_first", 64'(ack_cyc[0] - t_start), 64'(4));
    for (int i = 1; i < 4; i++) chk($sformatf("dm_only_gap_%0d", i), 64'(ack_cyc[i] - ack_cyc[i-1]), 64'(4));
    chk("dm_only_streak", 64'(dut.streak), 64'(0));

    // Reset in the second BUSY cycle of a fetch
    @(posedge clk); #1;
    b.if_req = 1'b1; b.if_addr = 64'h40;
    t0 = cyc;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; b.if_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_cycle", 64'(cyc - t0), 64'(3));
    chk("rst_mid_mem_en", 64'(b.mem_en), 64'(0));
    chk("rst_mid_mem_we", 64'(b.mem_we), 64'(0));
    chk("rst_mid_mem_addr", b.mem_addr, 64'h0);
    chk("rst_mid_mem_wdata", b.mem_wdata, 64'h0);
    chk("rst_mid_if_ack", 64'(b.if_ack), 64'(0));
    chk("rst_mid_dm_ack", 64'(b.dm_ack), 64'(0));
    chk("rst_mid_if_rdata", b.if_rdata, 64'h0);
    chk("rst_mid_dm_rdata", b.dm_rdata, 64'h0);
    chk("rst_mid_conflict", 64'(b.conflict_cnt), 64'(0));
    swe = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (b.if_ack === 1'b1) swe = 1;
    end
    chk("rst_mid_no_ack", 64'(swe), 64'(0));
    do_req(1'b0, 1'b0, 64'h40, 64'h0, lat, rdv, swe);
    chk("post_rst_fetch_lat", 64'(lat), 64'(4));
    chk("post_rst_fetch_rdata", rdv, 64'h0050_0093);

    // Saturation of the conflict counter
    @(posedge clk); #1;
    force dut.conflict_cnt = 16'hFFFD;
    m_conf = 16'hFFFD;
    @(posedge clk); #1;
    release dut.conflict_cnt;
    @(negedge clk);
    chk("conflict_preset", 64'(b.conflict_cnt), 64'hFFFD);
    run(1'b1, 1'b1, 4);
    @(negedge clk);
    chk("conflict_saturated", 64'(b.conflict_cnt), 64'hFFFF);

    // Latency extremes
    lat_test(1'b0, 1);
    lat_test(1'b1, 15);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end
endmodule
